// File: rtl/keypad_pkg.sv
// Shared types and width helpers for the keypad scanner.
package keypad_pkg;

  typedef enum logic [1:0] {
    SCAN     = 2'd0,
    DEBOUNCE = 2'd1,
    HOLD     = 2'd2,
    RELEASE  = 2'd3
  } scan_state_t;

  // Width of a counter that must be able to hold its terminal value.
  function automatic int cnt_width(input int terminal);
    return $clog2(terminal) + 1;
  endfunction

  // Width of an index into n items (at least one bit).
  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  function automatic int max_int(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/keypad_tick_gen.sv
// Free-running divider producing a one-cycle scan tick every TICK_DIV clocks.
module keypad_tick_gen #(
  parameter int TICK_DIV = 48000
) (
  input  logic clk,
  input  logic reset,
  output logic tick
);

  localparam int              CNT_W = $clog2(TICK_DIV);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(TICK_DIV - 1);

  logic [CNT_W-1:0] cnt;

  assign tick = (cnt == LAST);

  // Count 0..TICK_DIV-1 and wrap on the tick cycle.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt <= '0;
    end else if (tick) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + CNT_W'(1);
    end
  end

endmodule

// File: rtl/keypad_scanner.sv
// Row-scanning matrix keypad controller with debounce and auto-repeat.
module keypad_scanner
  import keypad_pkg::*;
#(
  parameter int NROWS          = 4,
  parameter int NCOLS          = 4,
  parameter int TICK_DIV       = 48000,
  parameter int DEBOUNCE_TICKS = 50,
  parameter int REPEAT_DELAY   = 500,
  parameter int REPEAT_RATE    = 100
) (
  input  logic                             clk,
  input  logic                             reset,
  input  logic [NCOLS-1:0]                 col,
  input  logic                             repeat_en,
  output logic [NROWS-1:0]                 row,
  output logic                             key_valid,
  output logic [$clog2(NROWS*NCOLS)-1:0]   key_code,
  output logic                             key_held
);

  localparam int CODE_W = $clog2(NROWS * NCOLS);
  localparam int RIDX_W = idx_width(NROWS);
  localparam int CIDX_W = idx_width(NCOLS);
  localparam int DEB_W  = cnt_width(DEBOUNCE_TICKS);
  localparam int RPT_W  = cnt_width(max_int(REPEAT_DELAY, REPEAT_RATE));

  localparam logic [RIDX_W-1:0] ROW_LAST   = RIDX_W'(NROWS - 1);
  localparam logic [NROWS-1:0]  ROW_ONE    = NROWS'(1);
  localparam logic [NCOLS-1:0]  COL_ONE    = NCOLS'(1);
  localparam logic [DEB_W-1:0]  DEB_LAST   = DEB_W'(DEBOUNCE_TICKS - 1);
  localparam logic [RPT_W-1:0]  DELAY_LAST = RPT_W'(REPEAT_DELAY - 1);
  localparam logic [RPT_W-1:0]  RATE_LAST  = RPT_W'(REPEAT_RATE - 1);

  logic              tick;
  logic [NCOLS-1:0]  col_meta, col_s;
  scan_state_t       state, state_nxt;
  logic [RIDX_W-1:0] row_idx, row_idx_nxt, row_idx_inc;
  logic [NCOLS-1:0]  key_col, key_col_nxt;
  logic [DEB_W-1:0]  deb_cnt, deb_nxt;
  logic [RPT_W-1:0]  rpt_cnt, rpt_nxt;
  logic              rpt_armed, rpt_armed_nxt;
  logic              key_valid_nxt, key_held_nxt;
  logic [CODE_W-1:0] key_code_nxt, accept_code;
  logic [CIDX_W-1:0] col_idx;
  logic              col_onehot, key_bit, deb_hit, rpt_hit;

  keypad_tick_gen #(
    .TICK_DIV (TICK_DIV)
  ) u_tick_gen (
    .clk   (clk),
    .reset (reset),
    .tick  (tick)
  );

  // Two-flop synchroniser for the asynchronous column sense lines.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      col_meta <= '0;
      col_s    <= '0;
    end else begin
      // NOTE: non-blocking so the second stage takes the first stage's pre-edge value.
      col_meta <= col;
      col_s    <= col_meta;
    end
  end

  assign row         = ROW_ONE << row_idx;
  assign row_idx_inc = (row_idx == ROW_LAST) ? '0 : row_idx + RIDX_W'(1);
  assign col_onehot  = (col_s != '0) && ((col_s & (col_s - COL_ONE)) == '0);
  assign key_bit     = |(col_s & key_col);
  assign deb_hit     = (deb_cnt == DEB_LAST);
  assign rpt_hit     = rpt_armed ? (rpt_cnt == RATE_LAST) : (rpt_cnt == DELAY_LAST);
  assign accept_code = CODE_W'(row_idx) * CODE_W'(NCOLS) + CODE_W'(col_idx);

  // Encode the latched one-hot column into its index.
  always_comb begin
    col_idx = '0;
    for (int i = 0; i < NCOLS; i++) begin
      if (key_col[i]) col_idx = CIDX_W'(i);
    end
  end

  // State register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= SCAN;
    else       state <= state_nxt;
  end

  // Next-state and datapath decisions; everything except repeat clearing waits for a tick.
  always_comb begin
    // NOTE: every target gets a default first so no latch is inferred.
    state_nxt     = state;
    row_idx_nxt   = row_idx;
    key_col_nxt   = key_col;
    deb_nxt       = deb_cnt;
    rpt_nxt       = rpt_cnt;
    rpt_armed_nxt = rpt_armed;
    key_valid_nxt = 1'b0;
    key_code_nxt  = key_code;
    key_held_nxt  = key_held;
    case (state)
      SCAN: begin
        if (tick) begin
          if (col_onehot) begin
            key_col_nxt = col_s;
            deb_nxt     = '0;
            state_nxt   = DEBOUNCE;
          end else begin
            row_idx_nxt = row_idx_inc;
          end
        end
      end
      DEBOUNCE: begin
        if (tick) begin
          if (col_s == key_col) begin
            if (deb_hit) begin
              state_nxt     = HOLD;
              deb_nxt       = '0;
              key_valid_nxt = 1'b1;
              key_code_nxt  = accept_code;
              key_held_nxt  = 1'b1;
              rpt_nxt       = '0;
              rpt_armed_nxt = 1'b0;
            end else begin
              deb_nxt = deb_cnt + DEB_W'(1);
            end
          end else begin
            deb_nxt     = '0;
            state_nxt   = SCAN;
            row_idx_nxt = row_idx_inc;
          end
        end
      end
      HOLD: begin
        if (tick && !key_bit) begin
          state_nxt = RELEASE;
          deb_nxt   = '0;
        end else if (!repeat_en) begin
          rpt_nxt       = '0;
          rpt_armed_nxt = 1'b0;
        end else if (tick) begin
          if (rpt_hit) begin
            key_valid_nxt = 1'b1;
            rpt_nxt       = '0;
            rpt_armed_nxt = 1'b1;
          end else begin
            rpt_nxt = rpt_cnt + RPT_W'(1);
          end
        end
      end
      RELEASE: begin
        if (tick) begin
          if (key_bit) begin
            // Release bounce: back to HOLD silently, repeat timing kept.
            state_nxt = HOLD;
            deb_nxt   = '0;
          end else if (deb_hit) begin
            state_nxt    = SCAN;
            deb_nxt      = '0;
            row_idx_nxt  = row_idx_inc;
            key_held_nxt = 1'b0;
          end else begin
            deb_nxt = deb_cnt + DEB_W'(1);
          end
        end
      end
      default: state_nxt = SCAN;
    endcase
  end

  // Datapath and output registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      row_idx   <= '0;
      key_col   <= '0;
      deb_cnt   <= '0;
      rpt_cnt   <= '0;
      rpt_armed <= 1'b0;
      key_valid <= 1'b0;
      key_code  <= '0;
      key_held  <= 1'b0;
    end else begin
      row_idx   <= row_idx_nxt;
      key_col   <= key_col_nxt;
      deb_cnt   <= deb_nxt;
      rpt_cnt   <= rpt_nxt;
      rpt_armed <= rpt_armed_nxt;
      key_valid <= key_valid_nxt;
      key_code  <= key_code_nxt;
      key_held  <= key_held_nxt;
    end
  end

endmodule

// File: tb/tb_keypad_scanner.sv
// Self-checking bench for keypad_scanner with a cycle-level behavioural keypad model.
module tb_keypad_scanner;

  localparam int NR = 4;
  localparam int NC = 4;
  localparam int TD = 4;
  localparam int DB = 3;
  localparam int RD = 6;
  localparam int RR = 2;

  localparam int P_SCAN = 0;
  localparam int P_DEB  = 1;
  localparam int P_HOLD = 2;
  localparam int P_REL  = 3;

  logic          clk = 1'b0;
  logic          reset;
  logic          repeat_en;
  logic [NC-1:0] col;
  logic [NR-1:0] row;
  logic          key_valid;
  logic [3:0]    key_code;
  logic          key_held;

  logic [NR*NC-1:0] pressed;

  int n_checks   = 0;
  int n_errors   = 0;
  int dut_valids = 0;
  int exp_off[4] = '{6, 8, 10, 12};

  // Reference model state.
  int            m_phase, m_row, m_col, m_stable, m_rep, m_code, m_tcnt;
  bit            m_valid, m_held, m_ticked;
  logic [NC-1:0] m_s1, m_s2;

  keypad_scanner #(
    .NROWS          (NR),
    .NCOLS          (NC),
    .TICK_DIV       (TD),
    .DEBOUNCE_TICKS (DB),
    .REPEAT_DELAY   (RD),
    .REPEAT_RATE    (RR)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .col       (col),
    .repeat_en (repeat_en),
    .row       (row),
    .key_valid (key_valid),
    .key_code  (key_code),
    .key_held  (key_held)
  );

  always #5 clk = ~clk;

  // Keypad matrix: a pressed key connects its row line to its column line.
  always_comb begin
    col = '0;
    for (int r = 0; r < NR; r++) begin
      if (row[r]) col = col | pressed[r*NC +: NC];
    end
  end

  function automatic logic [NC-1:0] kp(input int r);
    return pressed[r*NC +: NC];
  endfunction

  function automatic logic [NC-1:0] mask(input int c);
    logic [NC-1:0] m;
    m    = '0;
    m[c] = 1'b1;
    return m;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic set_key(input int r, input int c);
    pressed[r*NC + c] = 1'b1;
  endtask

  // Advance one clock, step the model, compare every output.
  task automatic cycle();
    logic [NC-1:0] cin, cs;
    logic          ren;
    bit            tk;
    cin = kp(m_row);
    ren = repeat_en;
    @(posedge clk);
    cs       = m_s2;
    tk       = (m_tcnt == TD - 1);
    m_s2     = m_s1;
    m_s1     = cin;
    m_tcnt   = tk ? 0 : m_tcnt + 1;
    m_ticked = tk;
    m_valid  = 1'b0;
    case (m_phase)
      P_SCAN: if (tk) begin
        if ($countones(cs) == 1) begin
          for (int i = 0; i < NC; i++) if (cs[i]) m_col = i;
          m_stable = 0;
          m_phase  = P_DEB;
        end else begin
          m_row = (m_row + 1) % NR;
        end
      end
      P_DEB: if (tk) begin
        if (cs == mask(m_col)) begin
          m_stable++;
          if (m_stable == DB) begin
            m_phase = P_HOLD;
            m_valid = 1'b1;
            m_held  = 1'b1;
            m_code  = m_row * NC + m_col;
            m_rep   = 0;
          end
        end else begin
          m_phase = P_SCAN;
          m_row   = (m_row + 1) % NR;
        end
      end
      P_HOLD: begin
        if (tk && !cs[m_col]) begin
          m_phase  = P_REL;
          m_stable = 0;
        end else if (!ren) begin
          m_rep = 0;
        end else if (tk) begin
          m_rep++;
          if (m_rep == RD || (m_rep > RD && (m_rep - RD) % RR == 0)) m_valid = 1'b1;
        end
      end
      default: if (tk) begin
        if (cs[m_col]) begin
          m_phase = P_HOLD;
        end else begin
          m_stable++;
          if (m_stable == DB) begin
            m_phase = P_SCAN;
            m_row   = (m_row + 1) % NR;
            m_held  = 1'b0;
          end
        end
      end
    endcase
    #1;
    if (key_valid === 1'b1) dut_valids++;
    check("row",       32'(row),       32'(1 << m_row));
    check("key_valid", 32'(key_valid), 32'(m_valid));
    check("key_held",  32'(key_held),  32'(m_held));
    check("key_code",  32'(key_code),  32'(m_code));
  endtask

  task automatic run_ticks(input int n);
    repeat (n * TD) cycle();
  endtask

  // Asynchronous reset mid-cycle: outputs must clear without waiting for an edge.
  task automatic do_reset(input string tag);
    reset    = 1'b1;
    m_phase  = P_SCAN;
    m_row    = 0;
    m_col    = 0;
    m_stable = 0;
    m_rep    = 0;
    m_code   = 0;
    m_tcnt   = 0;
    m_valid  = 1'b0;
    m_held   = 1'b0;
    m_ticked = 1'b0;
    m_s1     = '0;
    m_s2     = '0;
    #1;
    check({tag, "_rst_row"},   32'(row),       32'd1);
    check({tag, "_rst_valid"}, 32'(key_valid), 32'd0);
    check({tag, "_rst_held"},  32'(key_held),  32'd0);
    check({tag, "_rst_code"},  32'(key_code),  32'd0);
    @(posedge clk);
    @(posedge clk);
    #1;
    reset = 1'b0;
  endtask

  task automatic wait_accept(input string tag, input int max_ticks, output int cycles);
    cycles = 0;
    while (key_valid !== 1'b1 && cycles < max_ticks * TD) begin
      cycle();
      cycles++;
    end
    check({tag, "_accept"}, 32'(key_valid), 32'd1);
  endtask

  initial begin
    int v0, k, got;
    pressed   = '0;
    repeat_en = 1'b0;
    do_reset("init");

    // Single press row2/col1 held 20 ticks, then release.
    v0 = dut_valids;
    set_key(2, 1);
    wait_accept("s1", 24, k);
    check("s1_code", 32'(key_code), 32'd9);
    run_ticks(19);
    pressed = '0;
    run_ticks(3);
    check("s1_held_3t", 32'(key_held), 32'd1);
    run_ticks(1);
    check("s1_held_4t", 32'(key_held), 32'd0);
    check("s1_valids", 32'(dut_valids - v0), 32'd1);
    check("s1_code_kept", 32'(key_code), 32'd9);
    run_ticks(2);

    // Bounce on row0, then a clean press of column 2.
    k = 0;
    while (!(m_row == 0 && m_ticked) && k < 64) begin
      cycle();
      k++;
    end
    check("s2_align_row", 32'(row), 32'd1);
    v0 = dut_valids;
    for (int b = 0; b < 3; b++) begin
      set_key(0, 2);
      run_ticks(1);
      pressed = '0;
      run_ticks(1);
    end
    check("s2_bounce_valids", 32'(dut_valids - v0), 32'd0);
    set_key(0, 2);
    wait_accept("s2", 16, k);
    check("s2_code", 32'(key_code), 32'd2);
    pressed = '0;
    run_ticks(6);

    // Two columns on row1: never accepted, scan keeps rotating.
    do_reset("s3");
    v0 = dut_valids;
    set_key(1, 0);
    set_key(1, 3);
    for (int t = 1; t <= 8; t++) begin
      run_ticks(1);
      check("s3_row", 32'(row), 32'(1 << (t % NR)));
    end
    check("s3_valids", 32'(dut_valids - v0), 32'd0);
    pressed = '0;
    run_ticks(2);

    // Auto-repeat on row3/col3.
    repeat_en = 1'b1;
    set_key(3, 3);
    wait_accept("s4", 16, k);
    check("s4_code_accept", 32'(key_code), 32'd15);
    got = 0;
    for (int t = 1; t <= 13; t++) begin
      run_ticks(1);
      if (key_valid === 1'b1) begin
        if (got < 4) check("s4_offset", 32'(t), 32'(exp_off[got]));
        else         check("s4_extra_pulse", 32'(key_valid), 32'd0);
        check("s4_code_repeat", 32'(key_code), 32'd15);
        got++;
      end
    end
    check("s4_repeat_count", 32'(got), 32'd4);
    pressed = '0;
    run_ticks(6);
    repeat_en = 1'b0;

    // Release glitch: low for 2 ticks, back high, then a real release.
    v0 = dut_valids;
    set_key(1, 2);
    wait_accept("s5", 16, k);
    run_ticks(3);
    pressed = '0;
    run_ticks(2);
    set_key(1, 2);
    run_ticks(1);
    check("s5_held_after_glitch", 32'(key_held), 32'd1);
    run_ticks(3);
    pressed = '0;
    run_ticks(5);
    check("s5_valids", 32'(dut_valids - v0), 32'd1);
    check("s5_held_end", 32'(key_held), 32'd0);

    // Reset during DEBOUNCE, full re-debounce, then reset during HOLD.
    do_reset("s6a_pre");
    set_key(0, 1);
    k = 0;
    while (m_phase != P_DEB && k < 32) begin
      cycle();
      k++;
    end
    check("s6_reach_debounce", 32'(k < 32), 32'd1);
    run_ticks(1);
    check("s6_deb_no_valid", 32'(key_valid), 32'd0);
    do_reset("s6_deb");
    wait_accept("s6", 16, k);
    check("s6_reaccept_cycles", 32'(k), 32'(4 * TD));
    check("s6_code", 32'(key_code), 32'd1);
    run_ticks(2);
    do_reset("s6_hold");
    pressed = '0;
    run_ticks(4);

    // Randomised presses, holds, glitches and repeat settings.
    for (int it = 0; it < 25; it++) begin
      logic [NR*NC-1:0] save;
      pressed = '0;
      set_key(int'($urandom_range(0, NR - 1)), int'($urandom_range(0, NC - 1)));
      if ($urandom_range(0, 3) == 0) pressed[$urandom_range(0, NR*NC - 1)] = 1'b1;
      repeat_en = 1'($urandom_range(0, 1));
      repeat ($urandom_range(0, 3)) cycle();
      run_ticks(int'($urandom_range(1, 20)));
      if ($urandom_range(0, 3) == 0) begin
        save    = pressed;
        pressed = '0;
        run_ticks(int'($urandom_range(1, 2)));
        pressed = save;
        run_ticks(int'($urandom_range(1, 6)));
      end
      pressed = '0;
      run_ticks(int'($urandom_range(1, 8)));
      if (it == 12) do_reset("rnd");
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/keypad_scanner.md
KEYPAD_SCANNER -- requirements
Module: keypad_scanner

Interface
REQ-001 Parameter NROWS, default 4: number of keypad rows driven; legal range 2..8.
REQ-002 Parameter NCOLS, default 4: number of keypad columns sensed; legal range 2..8.
REQ-003 Parameter TICK_DIV, default 48000: clk cycles per scan tick (1 kHz at 48 MHz); minimum 2.
REQ-004 Parameter DEBOUNCE_TICKS, default 50: consecutive stable ticks needed to accept a press and, separately, a release; minimum 1.
REQ-005 Parameter REPEAT_DELAY, default 500: ticks from accept to first auto-repeat.
REQ-006 Parameter REPEAT_RATE, default 100: ticks between later auto-repeats.
REQ-007 clk  input  1  the single clock; every flop is clocked on posedge clk.
REQ-008 reset  input  1  asynchronous, active-high reset.
REQ-009 col  input  NCOLS  raw column sense, active-high, asynchronous to clk.
REQ-010 repeat_en  input  1  enables auto-repeat while a key is held.
REQ-011 row  output  NROWS  one-hot row drive.
REQ-012 key_valid  output  1  single-cycle pulse per accepted press or repeat.
REQ-013 key_code  output  clog2(NROWS*NCOLS)  row_idx*NCOLS + col_idx of the current key.
REQ-014 key_held  output  1  high from accept until release is accepted.

Function
REQ-015 col SHALL pass through a 2-flop synchroniser; all decisions use the synchronised value (col_s).
REQ-016 The tick SHALL be a one-cycle pulse every TICK_DIV clk cycles; state changes and counters advance only on tick.
REQ-017 States: SCAN, DEBOUNCE, HOLD, RELEASE; row SHALL be 1 << row_idx in every state.
REQ-018 SCAN: on tick, if col_s has exactly one bit set, latch that bit as key_col and go to DEBOUNCE; otherwise row_idx increments, NROWS-1 wrapping to 0.
REQ-019 SCAN with zero or two-plus bits set SHALL NOT latch; multi-column presses are never accepted.
REQ-020 DEBOUNCE: on tick, col_s equal to key_col increments deb_cnt; on reaching DEBOUNCE_TICKS go to HOLD; any other value clears deb_cnt, returns to SCAN and advances row_idx.
REQ-021 On entry to HOLD, key_code SHALL update and key_valid SHALL pulse in the same cycle; key_held rises with it.
REQ-022 HOLD: added columns are ignored; key_col bit low on a tick moves to RELEASE with deb_cnt cleared.
REQ-023 HOLD with repeat_en high: rpt_cnt counts ticks; key_valid pulses with unchanged key_code at REPEAT_DELAY, then every REPEAT_RATE; repeat_en low clears rpt_cnt.
REQ-024 RELEASE: DEBOUNCE_TICKS consecutive ticks with key_col bit low return to SCAN at row_idx+1 (wrapped) and drop key_held; bit high on any tick returns to HOLD with no key_valid and rpt_cnt preserved.
REQ-025 key_code SHALL hold its value until the next accept; key_valid SHALL never exceed one cycle.
REQ-026 Counters SHALL saturate at their terminal value; widths are clog2(terminal)+1.

Reset
REQ-027 reset SHALL asynchronously force SCAN, row_idx=0 (row=1), key_valid=0, key_held=0, key_code=0, all counters and synchroniser flops to 0.
REQ-028 reset asserted mid-press SHALL discard the key; after release of reset, the first accept requires a full DEBOUNCE_TICKS again.

Structure
REQ-029 Package keypad_pkg SHALL hold the scan_state_t enum and width helper constants.
REQ-030 Sub-module keypad_tick_gen(TICK_DIV) SHALL produce the tick; all else lives in keypad_scanner.

Verification (TICK_DIV=4, DEBOUNCE_TICKS=3, REPEAT_DELAY=6, REPEAT_RATE=2, 4x4)
REQ-031 Press row2/col1 held 20 ticks -> exactly one key_valid, key_code=9, key_held high until 3 ticks after release.
REQ-032 Bounce: col toggles 1,0,1 over ticks on row0 -> no key_valid; a clean 3-tick press then gives key_code=col index.
REQ-033 Two columns on row1 -> no accept, scan keeps cycling row 1,2,4,8,1.
REQ-034 repeat_en=1, row3/col3 held 14 ticks -> key_valid at accept, +6, +8, +10, +12 ticks, key_code=15 each.
REQ-035 Release glitch: bit low 2 ticks then high in RELEASE -> returns to HOLD, no extra key_valid.
REQ-036 reset asserted during DEBOUNCE and during HOLD -> all outputs 0, row=1 within the same cycle.
